// File: rtl/gps_iq_readout_sched.sv
// Round-robin drain of per-channel serial IQ accumulator snapshots onto a valid/ready word stream.
// Per-channel pending/overrun bookkeeping sits in gps_iq_chan_flags, one instance per channel.

module gps_iq_chan_flags (
  input  logic clk,
  input  logic rst_n,
  input  logic chan_en,
  input  logic epoch,
  input  logic ovr_clr,
  input  logic done,
  output logic pend,
  output logic ovr
);
  logic pend_q, pend_d;
  logic ovr_q, ovr_d;

  // A fresh epoch always re-arms pending, even on the cycle the old snapshot completes.
  always_comb begin
    pend_d = (epoch & chan_en) | (pend_q & chan_en & ~done);
    ovr_d  = (epoch & pend_q & ~done) | (ovr_q & ~ovr_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pend = pend_q;
  assign ovr  = ovr_q;
endmodule

module gps_iq_readout_sched #(
  parameter int NCHAN      = 12,
  parameter int INTEG_BITS = 20,
  parameter int NWORDS     = 6,
  parameter int CH_BITS    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NCHAN-1:0]          chan_en,
  input  logic [NCHAN-1:0]          epoch,
  input  logic [NCHAN-1:0]          sout,
  output logic [NCHAN-1:0]          shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INTEG_BITS-1:0]     out_data,
  output logic [CH_BITS-1:0]        out_chan,
  output logic [$clog2(NWORDS)-1:0] out_word,
  output logic                      out_last,
  output logic [NCHAN-1:0]          overrun,
  input  logic [NCHAN-1:0]          ovr_clr
);
  localparam int WW = $clog2(NWORDS);
  localparam int BW = $clog2(INTEG_BITS);
  localparam logic [WW-1:0] LAST_WORD = WW'(NWORDS-1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(INTEG_BITS-1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PRESENT} state_e;

  state_e                state_q, state_d;
  logic [CH_BITS-1:0]    sel_q, sel_d;
  logic [CH_BITS-1:0]    rr_q, rr_d;
  logic [WW-1:0]         word_q, word_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [INTEG_BITS-1:0] sreg_q, sreg_d;
  logic                  abort_q, abort_d;

  logic [NCHAN-1:0]   pend, done, elig;
  logic               found, abort_now;
  logic [CH_BITS-1:0] pick, idx;

  for (genvar i = 0; i < NCHAN; i++) begin : g_ch
    gps_iq_chan_flags u_flags (
      .clk     (clk),
      .rst_n   (rst_n),
      .chan_en (chan_en[i]),
      .epoch   (epoch[i]),
      .ovr_clr (ovr_clr[i]),
      .done    (done[i]),
      .pend    (pend[i]),
      .ovr     (overrun[i])
    );
  end

  // A pending flag can lag a disable by one cycle; never pick a channel that is off right now.
  assign elig = pend & chan_en;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NCHAN; k++) begin
      idx = CH_BITS'((int'(rr_q) + k) % NCHAN);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign abort_now = epoch[sel_q] | ~chan_en[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    sreg_d  = sreg_q;
    abort_d = abort_q;
    done    = '0;
    shift   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          sel_d   = pick;
          word_d  = '0;
          bcnt_d  = '0;
          abort_d = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift[sel_q] = 1'b1;
        sreg_d       = {sreg_q[INTEG_BITS-2:0], sout[sel_q]};
        if (abort_now) begin
          rr_d    = sel_q;
          state_d = ST_IDLE;
        end else if (bcnt_q == LAST_BIT) begin
          state_d = ST_PRESENT;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      ST_PRESENT: begin
        // The held word stays on the stream; an abort only stops the snapshot after it is taken.
        if (abort_now) abort_d = 1'b1;
        if (out_ready) begin
          if (abort_q || abort_now) begin
            abort_d = 1'b0;
            rr_d    = sel_q;
            state_d = ST_IDLE;
          end else if (word_q == LAST_WORD) begin
            done[sel_q] = 1'b1;
            rr_d        = sel_q;
            state_d     = ST_IDLE;
          end else begin
            word_d  = word_q + 1'b1;
            bcnt_d  = '0;
            state_d = ST_SHIFT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      rr_q    <= CH_BITS'(NCHAN-1);
      word_q  <= '0;
      bcnt_q  <= '0;
      sreg_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      sreg_q  <= sreg_d;
      abort_q <= abort_d;
    end
  end

  assign out_valid = (state_q == ST_PRESENT);
  assign out_last  = (state_q == ST_PRESENT) && (word_q == LAST_WORD);
  assign out_data  = sreg_q;
  assign out_chan  = sel_q;
  assign out_word  = word_q;
endmodule

// File: tb/tb_gps_iq_readout_sched.sv
// Bench for gps_iq_readout_sched: behavioural demod channels feed sout, and a snapshot-level
// scoreboard predicts words, pending and overrun; directed scenarios then a randomized soak.

module tb_gps_iq_readout_sched;
  localparam int NCHAN = 12;
  localparam int IB    = 20;
  localparam int NW    = 6;
  localparam int CHB   = 4;
  localparam int WW    = $clog2(NW);
  localparam int TOT   = NW * IB;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCHAN-1:0]  chan_en = '1;
  logic [NCHAN-1:0]  epoch = '0;
  logic [NCHAN-1:0]  sout;
  logic [NCHAN-1:0]  shift;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [IB-1:0]     out_data;
  logic [CHB-1:0]    out_chan;
  logic [WW-1:0]     out_word;
  logic              out_last;
  logic [NCHAN-1:0]  overrun;
  logic [NCHAN-1:0]  ovr_clr = '0;

  gps_iq_readout_sched #(.NCHAN(NCHAN), .INTEG_BITS(IB), .NWORDS(NW), .CH_BITS(CHB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .chan_en   (chan_en),
    .epoch     (epoch),
    .sout      (sout),
    .shift     (shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_word  (out_word),
    .out_last  (out_last),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Demod channels: a snapshot loads at epoch, each shift strobe advances one bit, MSB first.
  logic [TOT-1:0] nsnap   [NCHAN] = '{default: '0};
  logic [TOT-1:0] cursnap [NCHAN] = '{default: '0};
  int             bitpos  [NCHAN] = '{default: 0};

  always_comb
    for (int i = 0; i < NCHAN; i++)
      sout[i] = (bitpos[i] < TOT) ? cursnap[i][TOT-1-bitpos[i]] : 1'b0;

  always @(posedge clk)
    for (int i = 0; i < NCHAN; i++)
      if (epoch[i]) begin
        cursnap[i] <= nsnap[i];
        bitpos[i]  <= 0;
      end else if (shift[i]) begin
        bitpos[i] <= bitpos[i] + 1;
      end

  // Snapshot-level reference: words of a channel arrive 0..NW-1 since its last epoch.
  logic [NCHAN-1:0] mpend = '0;
  logic [NCHAN-1:0] mover = '0;
  logic [TOT-1:0]   expsnap [NCHAN] = '{default: '0};
  int               wd [NCHAN] = '{default: 0};
  int               served [2048];
  int               nserved = 0;
  logic             prev_hold = 1'b0;
  logic [63:0]      prev_word = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mpend     = '0;
      mover     = '0;
      prev_hold = 1'b0;
      for (int i = 0; i < NCHAN; i++) wd[i] = 0;
    end else begin
      int ch;
      logic setb;
      chk("overrun", overrun, mover);
      chk("shift_onehot", $onehot0(shift), 1);
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_word", {out_chan, out_word, out_data}, prev_word);
      end
      prev_hold = out_valid & ~out_ready;
      prev_word = {out_chan, out_word, out_data};
      if (out_valid && out_ready) begin
        ch = int'(out_chan);
        if (ch >= NCHAN) begin
          chk("acc_chan_range", out_chan, 0);
        end else begin
          chk("acc_pend", mpend[ch], 1);
          chk("acc_word", out_word, wd[ch]);
          chk("acc_data", out_data, expsnap[ch][TOT-1-wd[ch]*IB -: IB]);
          chk("acc_last", out_last, wd[ch] == NW-1);
          if (wd[ch] == NW-1) begin
            wd[ch]    = 0;
            mpend[ch] = 1'b0;
            if (nserved < 2048) served[nserved] = ch;
            nserved++;
          end else begin
            wd[ch]++;
          end
        end
      end
      for (int i = 0; i < NCHAN; i++) begin
        setb     = epoch[i] & mpend[i];
        mover[i] = setb | (mover[i] & ~ovr_clr[i]);
        if (epoch[i]) expsnap[i] = nsnap[i];
        if (!chan_en[i]) begin
          mpend[i] = 1'b0;
          wd[i]    = 0;
        end else if (epoch[i]) begin
          mpend[i] = 1'b1;
          wd[i]    = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_snap(input int i);
    for (int w = 0; w < NW; w++) nsnap[i][w*IB +: IB] = IB'($urandom);
  endtask

  task automatic pulse(input logic [NCHAN-1:0] m);
    epoch = m;
    tick();
    epoch = '0;
  endtask

  task automatic wait_done(input string tag, input logic [NCHAN-1:0] m, input int budget);
    int n = 0;
    while ((mpend & m) != '0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, (mpend & m) == '0, 1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    chk(tag, out_valid, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, first_sh, nsh, first_v, unstab, shcnt, n, busy;
    logic [63:0] cap;

    // reset values
    #12;
    chk("rst_shift", shift, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_chan", out_chan, 0);
    chk("rst_word", out_word, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ovr", overrun, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // round robin from pointer NCHAN-1, then wrap past channel 9
    base = nserved;
    for (int i = 0; i < NCHAN; i++) rand_snap(i);
    pulse(NCHAN'((1 << 2) | (1 << 5) | (1 << 9)));
    wait_done("rr_tmo1", '1, 2000);
    chk("rr_first", served[base], 2);
    chk("rr_second", served[base+1], 5);
    chk("rr_third", served[base+2], 9);
    pulse(NCHAN'(1 | (1 << 10)));
    wait_done("rr_tmo2", '1, 2000);
    chk("rr_wrap_a", served[base+3], 10);
    chk("rr_wrap_b", served[base+4], 0);

    // single channel latency and exact data pattern
    nsnap[0] = {20'h80001, 20'h7FFFE, 20'hAAAAA, 20'h55555, 20'h12345, 20'hFEDCB};
    tick();
    epoch = NCHAN'(1);
    tick();
    epoch = '0;
    first_sh = -1; nsh = 0; first_v = -1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (shift[0]) begin
        nsh++;
        if (first_sh < 0) first_sh = c;
      end
      if (out_valid && first_v < 0) first_v = c;
    end
    chk("lat_first_shift", first_sh, 2);
    chk("lat_shift_cnt", nsh, IB);
    chk("lat_valid", first_v, 22);
    wait_done("lat_tmo", NCHAN'(1), 1000);

    // consumer stall in PRESENT
    out_ready = 1'b0;
    rand_snap(7);
    pulse(NCHAN'(1 << 7));
    wait_valid("hold_tmo", 200);
    @(negedge clk);
    cap = {out_chan, out_word, out_data};
    chk("hold_chan", out_chan, 7);
    chk("hold_w0", out_word, 0);
    unstab = 0; shcnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if ({out_chan, out_word, out_data} !== cap || !out_valid) unstab++;
      if (shift != '0) shcnt++;
    end
    chk("hold_stable", unstab, 0);
    chk("hold_noshift", shcnt, 0);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_valid("hold_tmo2", 200);
    chk("hold_next_word", out_word, 1);
    out_ready = 1'b1;
    wait_done("hold_done", NCHAN'(1 << 7), 1000);

    // double epoch before service, clear racing a new overrun
    out_ready = 1'b0;
    rand_snap(1);
    pulse(NCHAN'(1 << 1));
    wait_valid("ovr_tmo", 200);
    rand_snap(4);
    pulse(NCHAN'(1 << 4));
    tick();
    rand_snap(4);
    pulse(NCHAN'(1 << 4));
    chk("ovr4_set", overrun[4], 1);
    ovr_clr = NCHAN'(1 << 4);
    rand_snap(4);
    pulse(NCHAN'(1 << 4));
    ovr_clr = '0;
    chk("ovr4_setwins", overrun[4], 1);
    ovr_clr = NCHAN'(1 << 4);
    tick();
    ovr_clr = '0;
    chk("ovr4_clr", overrun[4], 0);
    out_ready = 1'b1;
    wait_done("ovr_done", NCHAN'((1 << 1) | (1 << 4)), 2000);

    // epoch on the selected channel at the 10th shift of word 3
    rand_snap(8);
    pulse(NCHAN'(1 << 8));
    n = 0;
    while (!(shift[8] && out_word == 3) && n < 1000) begin
      tick();
      n++;
    end
    chk("abort_reach", shift[8] && out_word == 3, 1);
    repeat (9) tick();
    rand_snap(8);
    pulse(NCHAN'(1 << 8));
    @(negedge clk);
    chk("abort_shift_low", shift, 0);
    chk("abort_ovr", overrun[8], 1);
    wait_done("abort_done", NCHAN'(1 << 8), 1000);
    ovr_clr = NCHAN'(1 << 8);
    tick();
    ovr_clr = '0;

    // disable mid-shift
    rand_snap(3);
    pulse(NCHAN'(1 << 3));
    n = 0;
    while (!shift[3] && n < 100) begin
      tick();
      n++;
    end
    repeat (5) tick();
    chan_en[3] = 1'b0;
    tick();
    @(negedge clk);
    chk("dis_shift", shift, 0);
    chk("dis_ovr", overrun[3], 0);
    tick();
    chan_en = '1;
    busy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid || shift != '0) busy++;
    end
    chk("dis_no_service", busy, 0);
    tick();

    // randomized soak
    for (int c = 0; c < 4000; c++) begin
      logic [NCHAN-1:0] m;
      m = '0;
      for (int i = 0; i < NCHAN; i++)
        if ($urandom_range(0, 149) == 0 && !shift[i] && !(out_valid && int'(out_chan) == i)) begin
          rand_snap(i);
          m[i] = 1'b1;
        end
      epoch     = m;
      ovr_clr   = ($urandom_range(0, 39) == 0) ? NCHAN'($urandom) : '0;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    epoch = '0;
    ovr_clr = '0;
    out_ready = 1'b1;
    wait_done("soak_drain", '1, 5000);
    ovr_clr = '1;
    tick();
    ovr_clr = '0;

    // asynchronous reset mid-transfer
    rand_snap(6);
    pulse(NCHAN'(1 << 6));
    n = 0;
    while (!shift[6] && n < 100) begin
      tick();
      n++;
    end
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_shift", shift, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_chan", out_chan, 0);
    chk("arst_word", out_word, 0);
    chk("arst_last", out_last, 0);
    chk("arst_ovr", overrun, 0);
    tick();
    rst_n = 1'b1;
    busy = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid || shift != '0) busy++;
    end
    chk("arst_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
